// File: rtl/barrel_shift_pkg.sv
// barrel_shift_pkg: operation encodings and helpers shared by the barrel shifter pipeline
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_ROL = 2'b01,
        OP_SRL = 2'b10,
        OP_SRA = 2'b11
    } shift_op_t;

    // Logical and arithmetic shifts fill vacated MSBs; both rotates wrap the LSBs around.
    function automatic logic is_shift(shift_op_t op);
        return op inside {OP_SRL, OP_SRA};
    endfunction

endpackage

// File: rtl/barrel_shift_pipe_stage.sv
// shift_stage: one pipeline level of the barrel shifter, a conditional 2^K right move plus its register
// Ports: clk, rst_n (async, active-low), advance (pipeline enable),
//        in_* (record from the previous level), out_* (this level's registered record).
module shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 0,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  shift_op_t        in_op,
    input  logic             in_fill,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt,
    output shift_op_t        out_op,
    output logic             out_fill
);
    localparam int S = 1 << K;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        shift_op_t        op;
        logic             fill;
    } stage_t;

    stage_t           q;
    logic [WIDTH-1:0] moved;

    always_comb
        moved = !in_amt[K]       ? in_data :
                is_shift(in_op)  ? {{S{in_fill}}, in_data[WIDTH-1:S]} :
                                   {in_data[S-1:0], in_data[WIDTH-1:S]};

    // Bubbles advance with everything else so the level spacing never changes.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else if (advance)
            q <= '{valid: in_valid, data: moved, amt: in_amt, op: in_op, fill: in_fill};

    assign out_valid = q.valid;
    assign out_data  = q.data;
    assign out_amt   = q.amt;
    assign out_op    = q.op;
    assign out_fill  = q.fill;
endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined rotate/shift unit (ROR, ROL, SRL, SRA) with valid/ready handshake
// Ports: clk, rst_n (async, active-low);
//        in_valid/in_ready/in_data/in_amt/in_op  operand side;
//        out_valid/out_ready/out_data/out_zero   result side, out_zero = (out_data == 0).
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  shift_op_t        in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);
    logic                        advance;
    logic [SHW:0]                v;
    logic [SHW:0]                f;
    logic [SHW:0][WIDTH-1:0]     d;
    logic [SHW:0][SHW-1:0]       a;
    shift_op_t [SHW:0]           o;
    logic                        unused;

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // Entry record: a left rotate by n is a right rotate by (WIDTH - n) mod WIDTH,
    // which is just the SHW-bit negation of the amount.
    assign v[0] = in_valid;
    assign d[0] = in_data;
    assign a[0] = (in_op == OP_ROL) ? -in_amt : in_amt;
    assign o[0] = in_op;
    assign f[0] = (in_op == OP_SRA) && in_data[WIDTH-1];

    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        shift_stage #(.WIDTH(WIDTH), .K(k), .SHW(SHW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .in_valid  (v[k]),
            .in_data   (d[k]),
            .in_amt    (a[k]),
            .in_op     (o[k]),
            .in_fill   (f[k]),
            .out_valid (v[k+1]),
            .out_data  (d[k+1]),
            .out_amt   (a[k+1]),
            .out_op    (o[k+1]),
            .out_fill  (f[k+1])
        );
    end

    assign out_valid = v[SHW];
    assign out_data  = d[SHW];
    assign out_zero  = ~|out_data;
    assign unused    = ^{a[SHW], o[SHW], f[SHW]};
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: scoreboard bench for barrel_shift_pipe at WIDTH = 16
module tb_barrel_shift_pipe;
    import barrel_shift_pkg::*;

    localparam int W = 16;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [3:0]   in_amt = '0;
    shift_op_t    in_op = OP_ROR;
    logic         out_valid;
    logic         out_ready = 1;
    logic [W-1:0] out_data;
    logic         out_zero;

    int           pass_cnt = 0;
    int           total = 0;
    logic [W-1:0] exp_q[$];

    barrel_shift_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic logic [W-1:0] ref_fn(input logic [W-1:0] x, input logic [3:0] a, input shift_op_t op);
        logic [31:0] t;
        case (op)
            OP_ROR:  begin t = {x, x} >> a; return t[15:0]; end
            OP_ROL:  begin t = {x, x} << a; return t[31:16]; end
            OP_SRL:  return x >> a;
            default: return W'($signed(x) >>> a);
        endcase
    endfunction

    // Monitor: pops one expectation for every result the consumer takes.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("out_data", out_data, e);
                chk("out_zero", out_zero, e == 0);
            end
        end
    end

    // Inputs change 1ns after the rising edge; acceptance is decided from the
    // stable value of in_ready at the falling edge.
    task automatic send(input logic [W-1:0] x, input logic [3:0] a, input shift_op_t op,
                        input logic [W-1:0] e, input bit push, output int stalls);
        in_valid = 1; in_data = x; in_amt = a; in_op = op;
        stalls = 0;
        @(negedge clk);
        while (!in_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        else if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [3:0]   a;
        shift_op_t    op;
        logic [W-1:0] e;
    } vec_t;

    vec_t vecs[$] = '{
        '{16'h8001, 4'd1,  OP_ROR, 16'hC000},
        '{16'hBEEF, 4'd0,  OP_ROR, 16'hBEEF},
        '{16'h8001, 4'd4,  OP_ROL, 16'h0018},
        '{16'h1234, 4'd12, OP_ROR, 16'h2341},
        '{16'h8000, 4'd15, OP_SRL, 16'h0001},
        '{16'h8000, 4'd15, OP_SRA, 16'hFFFF},
        '{16'h7FFF, 4'd15, OP_SRA, 16'h0000},
        '{16'h8001, 4'd1,  OP_ROL, 16'h0003},
        '{16'hA5C3, 4'd0,  OP_ROL, 16'hA5C3},
        '{16'hA5C3, 4'd0,  OP_SRA, 16'hA5C3},
        '{16'hF00F, 4'd4,  OP_SRA, 16'hFF00},
        '{16'hF00F, 4'd8,  OP_SRL, 16'h00F0}
    };

    initial begin
        int st;
        logic [W-1:0] x;
        logic [3:0]   a;
        shift_op_t    op;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data",  out_data, 0);
        chk("reset_out_zero",  out_zero, 1);
        chk("reset_in_ready",  in_ready, 1);
        rst_n = 1;

        foreach (vecs[i]) send(vecs[i].x, vecs[i].a, vecs[i].op, vecs[i].e, 1, st);
        drain();

        for (int i = 0; i < 20; i++) begin
            x  = W'($urandom);
            a  = 4'($urandom_range(0, 15));
            op = shift_op_t'($urandom_range(0, 3));
            send(x, a, op, ref_fn(x, a, op), 1, st);
            chk("stream_stall", st, 0);
        end
        drain();

        for (int i = 0; i < 4; i++) begin
            x = W'($urandom); a = 4'(i * 3 + 1); op = shift_op_t'(i);
            send(x, a, op, ref_fn(x, a, op), 1, st);
        end
        out_ready = 0;
        in_valid = 1; in_data = 16'h1357; in_amt = 4'd5; in_op = OP_ROL;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data",  out_data, exp_q[0]);
        end
        @(posedge clk); #1;
        out_ready = 1;
        send(16'h1357, 4'd5, OP_ROL, 16'h6AE2, 1, st);
        drain();

        send(16'h1111, 4'd1, OP_ROR, 16'h0, 0, st);
        send(16'h2222, 4'd2, OP_SRL, 16'h0, 0, st);
        send(16'h3333, 4'd3, OP_ROL, 16'h0, 0, st);
        rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data",  out_data, 0);
        chk("midrst_out_zero",  out_zero, 1);
        chk("midrst_in_ready",  in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_idle", out_valid, 0);
        send(16'h00F0, 4'd4, OP_SRA, 16'h000F, 1, st);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
